// File: rtl/drum_pipe_mult_if.sv
// Operand/result handshake bundle for drum_pipe_mult.
// slave is the multiplier's view; master is the producer/consumer side.
interface drum_pipe_mult_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] r;

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, r
  );

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, r
  );
endinterface

// File: rtl/drum_pipe_mult.sv
// drum_pipe_mult: 3-stage DRUM approximate multiplier with valid/ready flow.
// Each operand keeps its leading one plus the next K-2 bits; the lowest kept
// bit is forced to 1 to unbias the truncation.
// Optional macro DRUM_PIPE_PERF_CNT_EN adds a 32-bit result handshake counter.
module drum_pipe_mult #(
  parameter int N = 16,
  parameter int K = 6
) (
  input  logic clk,
  input  logic rst_n,
  drum_pipe_mult_if.slave bus
`ifdef DRUM_PIPE_PERF_CNT_EN
  ,
  output logic [31:0] result_cnt
`endif
);
  localparam int LW = $clog2(N);
  localparam int SW = LW + 1;
  localparam int PW = 2 * K;
  localparam int RW = 2 * N;

  if (N < 8 || N > 32) begin : g_bad_n
    $error("drum_pipe_mult: N must be in 8..32");
  end
  if (K < 3 || K > N) begin : g_bad_k
    $error("drum_pipe_mult: K must be in 3..N");
  end

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic sgn);
    return (sgn && x[N-1]) ? (~x + N'(1)) : x;
  endfunction

  function automatic logic [LW-1:0] lead_one(input logic [N-1:0] x);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  function automatic logic [K-1:0] mantissa(input logic [N-1:0] mag, input logic [LW-1:0] k);
    int ki;
    ki = int'(k);
    if (ki > K - 1) return K'(mag >> (ki - K + 1)) | K'(1);
    else            return mag[K-1:0];
  endfunction

  function automatic logic [SW-1:0] shift_of(input logic [LW-1:0] k);
    int ki;
    ki = int'(k);
    return (ki > K - 1) ? SW'(ki - K + 1) : '0;
  endfunction

  function automatic logic [RW-1:0] sign_restore(input logic [RW-1:0] v, input logic neg);
    return neg ? (~v + RW'(1)) : v;
  endfunction

  logic          vld_p0_d, vld_p0_q, vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic          sgn_p0_d, sgn_p0_q, sgn_p1_d, sgn_p1_q;
  logic [N-1:0]  mag_a_p0_d, mag_a_p0_q, mag_b_p0_d, mag_b_p0_q;
  logic [LW-1:0] k_a_p0_d, k_a_p0_q, k_b_p0_d, k_b_p0_q;
  logic [PW-1:0] prod_p1_d, prod_p1_q;
  logic [SW-1:0] sh_p1_d, sh_p1_q;
  logic [RW-1:0] r_d, r_q;
  logic [N-1:0]  mag_a_s1, mag_b_s1;
  logic [K-1:0]  mant_a_s2, mant_b_s2;
  logic          adv_p0, adv_p1, adv_p2, accept;

  assign adv_p2        = !vld_p2_q || bus.out_ready;
  assign adv_p1        = !vld_p1_q || adv_p2;
  assign adv_p0        = !vld_p0_q || adv_p1;
  assign bus.in_ready  = rst_n && adv_p0;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_p2_q;
  assign bus.r         = r_q;

  // S1: operand magnitudes, result sign and leading-one positions
  always_comb begin
    mag_a_s1   = magnitude(bus.a, bus.in_signed);
    mag_b_s1   = magnitude(bus.b, bus.in_signed);
    vld_p0_d   = adv_p0 ? accept : vld_p0_q;
    sgn_p0_d   = sgn_p0_q;
    mag_a_p0_d = mag_a_p0_q;
    mag_b_p0_d = mag_b_p0_q;
    k_a_p0_d   = k_a_p0_q;
    k_b_p0_d   = k_b_p0_q;
    if (accept) begin
      sgn_p0_d   = bus.in_signed & (bus.a[N-1] ^ bus.b[N-1]);
      mag_a_p0_d = mag_a_s1;
      mag_b_p0_d = mag_b_s1;
      k_a_p0_d   = lead_one(mag_a_s1);
      k_b_p0_d   = lead_one(mag_b_s1);
    end
  end

  // S2: truncate to K-bit mantissas, multiply, sum the shifts
  always_comb begin
    mant_a_s2 = mantissa(mag_a_p0_q, k_a_p0_q);
    mant_b_s2 = mantissa(mag_b_p0_q, k_b_p0_q);
    vld_p1_d  = adv_p1 ? vld_p0_q : vld_p1_q;
    sgn_p1_d  = sgn_p1_q;
    prod_p1_d = prod_p1_q;
    sh_p1_d   = sh_p1_q;
    if (adv_p1 && vld_p0_q) begin
      sgn_p1_d  = sgn_p0_q;
      prod_p1_d = PW'(mant_a_s2) * PW'(mant_b_s2);
      sh_p1_d   = shift_of(k_a_p0_q) + shift_of(k_b_p0_q);
    end
  end

  // S3: scale the product back up and restore the sign
  always_comb begin
    vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
    r_d      = r_q;
    if (adv_p2 && vld_p1_q) begin
      r_d = sign_restore(RW'(prod_p1_q) << sh_p1_q, sgn_p1_q);
    end
  end

  // Datapath registers between stages; their contents are qualified by the valid flags
  always_ff @(posedge clk) begin
    sgn_p0_q   <= sgn_p0_d;
    mag_a_p0_q <= mag_a_p0_d;
    mag_b_p0_q <= mag_b_p0_d;
    k_a_p0_q   <= k_a_p0_d;
    k_b_p0_q   <= k_b_p0_d;
    sgn_p1_q   <= sgn_p1_d;
    prod_p1_q  <= prod_p1_d;
    sh_p1_q    <= sh_p1_d;
  end

  // Stage valid flags and the visible result; reset flushes every beat in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      r_q      <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      r_q      <= r_d;
    end
  end

`ifdef DRUM_PIPE_PERF_CNT_EN
  logic [31:0] result_cnt_d, result_cnt_q;

  // Count delivered results; wraps naturally at 2^32
  always_comb begin
    result_cnt_d = result_cnt_q;
    if (vld_p2_q && bus.out_ready) result_cnt_d = result_cnt_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_cnt_q <= '0;
    else        result_cnt_q <= result_cnt_d;
  end

  assign result_cnt = result_cnt_q;
`endif
endmodule

// File: tb/tb_drum_pipe_mult.sv
// Self-checking bench for drum_pipe_mult (N=16, K=6).
module tb_drum_pipe_mult;
  localparam int N = 16;
  localparam int K = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  drum_pipe_mult_if #(.N(N)) bus ();

`ifdef DRUM_PIPE_PERF_CNT_EN
  logic [31:0] result_cnt;
  drum_pipe_mult #(.N(N), .K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .result_cnt(result_cnt));
`else
  drum_pipe_mult #(.N(N), .K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // Reference: approximate one magnitude as mantissa * 2^t
  function automatic void approx(input longint m, output longint mant, output int t);
    int k;
    if (m < (longint'(1) << K)) begin
      mant = m;
      t    = 0;
    end else begin
      k = 0;
      while ((m >> (k + 1)) != 0) k++;
      t    = k - K + 1;
      mant = (m >> t) | 1;
    end
  endfunction

  function automatic logic [31:0] drum_model(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint ma, mb, mant_a, mant_b, p;
    int ta, tb;
    bit neg;
    ma  = (s && a[15]) ? (longint'(65536) - longint'(a)) : longint'(a);
    mb  = (s && b[15]) ? (longint'(65536) - longint'(b)) : longint'(b);
    neg = s && (a[15] ^ b[15]);
    approx(ma, mant_a, ta);
    approx(mb, mant_b, tb);
    p = (mant_a * mant_b) * (longint'(1) << (ta + tb));
    if (neg) p = (longint'(1) << 32) - p;
    return p[31:0];
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(0, 63));
      2: begin
        case ($urandom_range(0, 3))
          0:       return 16'h8000;
          1:       return 16'hFFFF;
          2:       return 16'h7FFF;
          default: return 16'h0040;
        endcase
      end
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_beat(input logic [15:0] a, input logic [15:0] b, input logic s);
    bus.a         = a;
    bus.b         = b;
    bus.in_signed = s;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    set_beat(16'd5, 16'd7, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.r !== 32'h0) begin errors++; $display("FAIL reset_r: got %h expected 00000000", bus.r); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'd5, 16'd1000, 16'hFC18, 16'hFFFF, 16'h0000};
    logic [15:0] tb [5] = '{16'd7, 16'd3,    16'd3,    16'hFFFF, 16'h8000};
    logic        ts [5] = '{1'b0,  1'b0,     1'b1,     1'b0,     1'b1};
    logic [31:0] te [5] = '{32'h23, 32'hBD0, 32'hFFFFF430, 32'hF8100000, 32'h0};
    for (int v = 0; v < 5; v++) begin
      bit got, seen;
      int lat;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      set_beat(ta[v], tb[v], ts[v]);
      got = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        got = bus.in_ready;
        @(posedge clk);
        if (got) break;
      end
      #1;
      bus.in_valid = 1'b0;
      checks++;
      if (!got) begin errors++; $display("FAIL directed_accept[%0d]: got no accept expected accept", v); end
      lat  = 1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.out_valid) begin seen = 1; break; end
        @(posedge clk);
        lat++;
      end
      checks++;
      if (!seen || lat != 3) begin errors++; $display("FAIL directed_latency[%0d]: got %0d (seen=%0d) expected 3", v, lat, seen); end
      checks++;
      if (bus.r !== te[v]) begin errors++; $display("FAIL directed_r[%0d]: got %h expected %h", v, bus.r, te[v]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3] = '{16'd5, 16'd1000, 16'hFFFF};
    logic [15:0] tb [3] = '{16'd7, 16'd3,    16'hFFFF};
    logic [31:0] te [3] = '{32'h23, 32'hBD0, 32'hF8100000};
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      set_beat(ta[i], tb[i], 1'b0);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: got in_ready=%b expected 1", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready[%0d]: got %b expected 0", j, bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.r !== 32'h23) begin
        errors++; $display("FAIL b2b_hold[%0d]: got valid=%b r=%h expected valid=1 r=00000023", j, bus.out_valid, bus.r);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.r !== te[i]) begin
        errors++; $display("FAIL b2b_drain[%0d]: got valid=%b r=%h expected valid=1 r=%h", i, bus.out_valid, bus.r, te[i]);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got out_valid=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] exp_r;
    logic        exp_ready;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
      @(negedge clk);
      exp_ready = (q.size() < 3) || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b (occupancy %0d)", cyc, bus.in_ready, exp_ready, q.size());
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra_result[%0d]: got r=%h expected no result", cyc, bus.r);
        end else begin
          exp_r = bus.out_ready ? q.pop_front() : q[0];
          if (bus.r !== exp_r) begin errors++; $display("FAIL rand_r[%0d]: got %h expected %h", cyc, bus.r, exp_r); end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(drum_model(bus.a, bus.b, bus.in_signed));
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        exp_r = q.pop_front();
        checks++;
        if (bus.r !== exp_r) begin errors++; $display("FAIL rand_drain_r: got %h expected %h", bus.r, exp_r); end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_lost_beats: got %0d outstanding expected 0", q.size()); end
  endtask

  task automatic test_reset_flush();
    int nout, lat;
    logic [31:0] last_r;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_beat(16'd5, 16'd7, 1'b0);
    @(posedge clk);
    #1;
    set_beat(16'd1000, 16'd3, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.r !== 32'h0) begin
      errors++; $display("FAIL flush_outputs: got valid=%b r=%h expected valid=0 r=00000000", bus.out_valid, bus.r);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    set_beat(16'hFFFF, 16'hFFFF, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_first_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    nout   = 0;
    lat    = 0;
    last_r = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        nout++;
        last_r = bus.r;
        if (lat == 0) lat = c;
      end
      @(posedge clk);
    end
    checks++;
    if (nout != 1) begin errors++; $display("FAIL flush_result_count: got %0d expected 1", nout); end
    checks++;
    if (last_r !== 32'hF8100000 || lat != 3) begin
      errors++; $display("FAIL flush_result: got r=%h lat=%0d expected r=f8100000 lat=3", last_r, lat);
    end
  endtask

`ifdef DRUM_PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_cnt !== 32'd0) begin errors++; $display("FAIL cnt_reset: got %0d expected 0", result_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      set_beat(16'(i + 1), 16'd3, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (result_cnt !== 32'd10) begin errors++; $display("FAIL cnt_ten: got %0d expected 10", result_cnt); end
    force dut.result_cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.result_cnt_q;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      set_beat(16'd9, 16'd9, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (result_cnt !== 32'd0) begin errors++; $display("FAIL cnt_wrap: got %h expected 00000000", result_cnt); end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_beat(16'h0, 16'h0, 1'b0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_flush();
`ifdef DRUM_PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/drum_pipe_mult.md
DRUM_PIPE_MULT -- requirements
Module: drum_pipe_mult

Interface
REQ-001 SHALL have parameter N, default 16: operand width; legal range 8..32.
REQ-002 SHALL have parameter K, default 6: retained mantissa width; legal range 3..N. Out-of-range values SHALL be rejected at elaboration.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1: operand beat offered.
REQ-006 SHALL have port in_ready  output  1: operand beat accepted when in_valid and in_ready are both 1.
REQ-007 SHALL have port in_signed  input  1: 1 = two's-complement operands; sampled with the beat.
REQ-008 SHALL have ports a and b  input  N each: operands.
REQ-009 SHALL have port out_valid  output  1: result held valid.
REQ-010 SHALL have port out_ready  input  1: result consumed when out_valid and out_ready are both 1.
REQ-011 SHALL have port r  output  2N: approximate product.

Function
REQ-012 SHALL be a 3-stage pipeline:
- S1: magnitude, sign and leading-one index.
- S2: mantissa truncation and K x K multiply.
- S3: shift and sign restore.
REQ-013 Latency SHALL be 3 cycles from acceptance to out_valid when out_ready is held at 1; throughput SHALL be 1 beat per cycle.
REQ-014 Each stage SHALL advance when its downstream stage is empty or advancing; in_ready SHALL be high when S1 is empty or advancing (combinational from out_ready).
REQ-015 While out_valid=1 and out_ready=0, r and out_valid SHALL hold stable; no beat SHALL be lost or reordered; at most 3 beats in flight.
REQ-016 Magnitude: in_signed=0 SHALL use x unchanged; in_signed=1 and x[N-1]=1 SHALL use -x as an N-bit unsigned value (-2^(N-1) maps to 2^(N-1)). Result sign = sa XOR sb.
REQ-017 Leading-one index k SHALL be the highest set bit of the magnitude.
- k > K-1: mantissa = {1, mag[k-1 : k-K+2], 1}, shift = k-K+1.
- Otherwise: mantissa = mag[K-1:0], shift = 0.
REQ-018 r SHALL be (mant_a * mant_b) << (shift_a + shift_b), zero-extended to 2N bits, then two's-negated if the result sign is 1.
REQ-019 Any zero operand SHALL yield r=0 regardless of sign.
REQ-020 Both magnitudes < 2^K SHALL yield the exact product.

Reset
REQ-021 With rst_n=0: all stage valid flags, out_valid and r SHALL be 0, and in_ready SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat after release SHALL be accepted in the first cycle with rst_n=1 and in_valid=1.

Configuration
REQ-023 Macro DRUM_PIPE_PERF_CNT_EN defined: SHALL add output port result_cnt  output  32.
- Increments on each out_valid and out_ready handshake.
- Wraps 0xFFFFFFFF to 0.
- Reset to 0 by rst_n.
REQ-024 Macro undefined: the result_cnt port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification (N=16, K=6, out_ready=1 unless stated)
REQ-025 a=5, b=7, in_signed=0 -> r=35 (0x00000023) exactly 3 cycles after acceptance.
REQ-026 a=1000, b=3, in_signed=0 -> r=3024 (0x00000BD0); with a=0xFC18 (-1000), b=3, in_signed=1 -> r=0xFFFFF430.
REQ-027 a=0xFFFF, b=0xFFFF, in_signed=0 -> r=0xF8100000; a=0, b=0x8000, in_signed=1 -> r=0.
REQ-028 Back-to-back beats (5,7), (1000,3), (0xFFFF,0xFFFF) with out_ready=0 for 6 cycles:
- in_ready drops after 3 accepts and r holds 35.
- On release, results come out in order on consecutive cycles.
REQ-029 Reset pulse with 2 beats in flight -> out_valid=0 and r=0 immediately; no stale result appears after release.
REQ-030 DRUM_PIPE_PERF_CNT_EN defined, 10 handshakes -> result_cnt=10; result_cnt preset near wrap -> rolls to 0.
